// File: rtl/fpadd_scheduler_if.sv
// Purpose : bundles the requester, adder and result signals of the FP-add scheduler.
// Latency : n/a (wiring only).
// Backpressure : none here; grants are produced by the scheduler on the slave side.
//
// Ports (by modport):
//   slave  - the scheduler: takes requests, operands and add_result; drives grants,
//            adder operands, the returned sum, its valid strobes and busy.
//   master - the surroundings: requesters plus the adder itself.
interface fpadd_scheduler_if #(
  parameter int DATA_W = 32
) ();

  // requester 0
  logic              req0;
  logic [DATA_W-1:0] a0_in;
  logic [DATA_W-1:0] b0_in;
  logic              gnt0;

  // requester 1
  logic              req1;
  logic [DATA_W-1:0] a1_in;
  logic [DATA_W-1:0] b1_in;
  logic              gnt1;

  // shared adder
  logic [DATA_W-1:0] reg_A;
  logic [DATA_W-1:0] reg_B;
  logic [DATA_W-1:0] add_result;

  // result return
  logic [DATA_W-1:0] res_data;
  logic              res_valid0;
  logic              res_valid1;
  logic              busy;

  modport slave (
    input  req0, a0_in, b0_in,
    input  req1, a1_in, b1_in,
    input  add_result,
    output gnt0, gnt1,
    output reg_A, reg_B,
    output res_data, res_valid0, res_valid1,
    output busy
  );

  modport master (
    output req0, a0_in, b0_in,
    output req1, a1_in, b1_in,
    output add_result,
    input  gnt0, gnt1,
    input  reg_A, reg_B,
    input  res_data, res_valid0, res_valid1,
    input  busy
  );

endinterface

// File: rtl/fpadd_scheduler.sv
// Purpose : round-robin sharing of one pipelined FP adder between two requesters.
// Latency : grant is combinational; sum returns ADD_LATENCY edges after the issue edge, +1 for res_data.
// Backpressure : none -- adder accepts one pair per cycle, so any request is granted the same cycle.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   bus   - fpadd_scheduler_if.slave: req/operands/gnt per requester, reg_A/reg_B and
//           add_result towards the adder, res_data/res_valid0/res_valid1/busy back out.
module fpadd_scheduler #(
  parameter int DATA_W      = 32,
  parameter int ADD_LATENCY = 3    // legal 1..8
) (
  input  logic             clk,
  input  logic             reset,
  fpadd_scheduler_if.slave bus
);

  // 0: requester 0 wins a contested cycle, 1: requester 1 wins.
  logic prio;

  logic xfer;
  logic xfer_id;

  // Tag pipe: stage k holds the tag of the pair issued k+1 edges ago, so the
  // last stage lines up with add_result on the edge that must capture it.
  logic [ADD_LATENCY-1:0] tag_vld;
  logic [ADD_LATENCY-1:0] tag_id;
  logic [ADD_LATENCY-1:0] tag_vld_nxt;
  logic [ADD_LATENCY-1:0] tag_id_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration. Gated by reset so nothing is granted while the block is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.gnt0 = 1'b0;
    bus.gnt1 = 1'b0;
    if (reset) begin
      if (bus.req0 && (!bus.req1 || !prio)) begin
        bus.gnt0 = 1'b1;
      end else if (bus.req1) begin
        bus.gnt1 = 1'b1;
      end
    end
  end

  assign xfer    = bus.gnt0 | bus.gnt1;
  assign xfer_id = bus.gnt1;

  // ---------------------------------------------------------------------------
  // Tag pipe next state. A bubble enters with id 0; only the valid bit matters.
  // ---------------------------------------------------------------------------
  generate
    if (ADD_LATENCY > 1) begin : g_tag_shift
      assign tag_vld_nxt = {tag_vld[ADD_LATENCY-2:0], xfer};
      assign tag_id_nxt  = {tag_id[ADD_LATENCY-2:0], xfer_id};
    end else begin : g_tag_single
      assign tag_vld_nxt = xfer;
      assign tag_id_nxt  = xfer_id;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Priority pointer: after a transfer the other requester gets priority.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (xfer) begin
      prio <= ~xfer_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue: operand registers hold their value while idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.reg_A <= '0;
      bus.reg_B <= '0;
    end else if (bus.gnt0) begin
      bus.reg_A <= bus.a0_in;
      bus.reg_B <= bus.b0_in;
    end else if (bus.gnt1) begin
      bus.reg_A <= bus.a1_in;
      bus.reg_B <= bus.b1_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipe and busy. busy reflects the tags present after this edge, so it
  // drops on the same edge the last tag retires.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld  <= '0;
      tag_id   <= '0;
      bus.busy <= 1'b0;
    end else begin
      tag_vld  <= tag_vld_nxt;
      tag_id   <= tag_id_nxt;
      bus.busy <= |tag_vld_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Return: capture add_result when the oldest tag is valid; bubbles leave
  // res_data untouched and keep both strobes low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.res_data   <= '0;
      bus.res_valid0 <= 1'b0;
      bus.res_valid1 <= 1'b0;
    end else begin
      bus.res_valid0 <= tag_vld[ADD_LATENCY-1] & ~tag_id[ADD_LATENCY-1];
      bus.res_valid1 <= tag_vld[ADD_LATENCY-1] &  tag_id[ADD_LATENCY-1];
      if (tag_vld[ADD_LATENCY-1]) begin
        bus.res_data <= bus.add_result;
      end
    end
  end

endmodule

// File: tb/tb_fpadd_scheduler.sv
module tb_fpadd_scheduler;

  localparam int DATA_W = 32;
  localparam int LAT    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpadd_scheduler_if #(.DATA_W(DATA_W)) bus ();

  fpadd_scheduler #(.DATA_W(DATA_W), .ADD_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------------------------------------------------------------------
  // Single-precision add via double arithmetic. Operands are kept to a narrow
  // exponent band so the double sum is exact and one RNE step gives the
  // correctly rounded single result.
  // ---------------------------------------------------------------------------
  function automatic real sp_to_real(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [24:0] m;
    logic        up;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e  = d[62:52] - 11'd896;
    up = d[28] && ((|d[27:0]) || d[29]);
    m  = {2'b01, d[51:29]} + {24'd0, up};
    if (m[24]) begin
      e = e + 11'd1;
      m = m >> 1;
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_sp(sp_to_real(a) + sp_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(120, 134));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Adder model: two register stages, so a pair on reg_A/reg_B after edge E0 is
  // visible on add_result for capture at edge E0+3.
  // ---------------------------------------------------------------------------
  logic [31:0] p1 = 32'd0;
  logic [31:0] p2 = 32'd0;
  always @(posedge clk) begin
    p1 <= fp_add(bus.reg_A, bus.reg_B);
    p2 <= p1;
  end
  assign bus.add_result = p2;

  // ---------------------------------------------------------------------------
  // Scoreboard: push on every observed grant, pop on every result strobe.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        id;
    logic [31:0] sum;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      last_a = 32'd0;
      last_b = 32'd0;
    end else begin
      checks++;
      if (bus.gnt0 && bus.gnt1) begin
        errors++;
        $display("FAIL gnt_onehot: gnt0=%0b gnt1=%0b, at most one expected", bus.gnt0, bus.gnt1);
      end
      checks++;
      if ((bus.gnt0 && !bus.req0) || (bus.gnt1 && !bus.req1)) begin
        errors++;
        $display("FAIL gnt_without_req: gnt=%0b%0b req=%0b%0b", bus.gnt1, bus.gnt0, bus.req1, bus.req0);
      end
      checks++;
      if (bus.res_valid0 && bus.res_valid1) begin
        errors++;
        $display("FAIL rv_onehot: res_valid0=1 res_valid1=1, at most one expected");
      end
      if (bus.res_valid0 || bus.res_valid1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: res_valid0=%0b res_valid1=%0b data=%h, none outstanding",
                   bus.res_valid0, bus.res_valid1, bus.res_data);
        end else begin
          e = sb.pop_front();
          if (bus.res_valid1 !== e.id || bus.res_data !== e.sum) begin
            errors++;
            $display("FAIL result: id=%0b data=%h, expected id=%0b data=%h",
                     bus.res_valid1, bus.res_data, e.id, e.sum);
          end
        end
      end
      if (bus.gnt0) begin
        sb.push_back('{id: 1'b0, sum: fp_add(bus.a0_in, bus.b0_in)});
        last_a = bus.a0_in;
        last_b = bus.b0_in;
      end else if (bus.gnt1) begin
        sb.push_back('{id: 1'b1, sum: fp_add(bus.a1_in, bus.b1_in)});
        last_a = bus.a1_in;
        last_b = bus.b1_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    set_idle();
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.a0_in = 32'h3F800000;
    bus.b0_in = 32'h3F800000;
    bus.a1_in = 32'h40000000;
    bus.b1_in = 32'h40000000;
    #3;
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_gnt: gnt0=%0b gnt1=%0b, expected 0 0", bus.gnt0, bus.gnt1);
    end
    checks++;
    if ({bus.reg_A, bus.reg_B, bus.res_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_regs: reg_A=%h reg_B=%h res_data=%h, expected all 0",
               bus.reg_A, bus.reg_B, bus.res_data);
    end
    checks++;
    if ({bus.res_valid0, bus.res_valid1, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: rv0=%0b rv1=%0b busy=%0b, expected 0 0 0",
               bus.res_valid0, bus.res_valid1, bus.busy);
    end
    set_idle();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: busy=%0b, expected 0", bus.busy);
    end
  endtask

  task automatic test_single();
    int k;
    tick();
    bus.a0_in = 32'h3F800000;
    bus.b0_in = 32'h40000000;
    bus.req0  = 1'b1;
    bus.req1  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt: gnt0=%0b gnt1=%0b, expected 1 0", bus.gnt0, bus.gnt1);
    end
    tick();
    bus.req0 = 1'b0;
    checks++;
    if (bus.reg_A !== 32'h3F800000 || bus.reg_B !== 32'h40000000) begin
      errors++;
      $display("FAIL single_issue: reg_A=%h reg_B=%h, expected 3f800000 40000000", bus.reg_A, bus.reg_B);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_on: busy=%0b, expected 1", bus.busy);
    end
    k = 0;
    for (int c = 1; c <= 8 && k == 0; c++) begin
      @(negedge clk);
      if (bus.res_valid0 === 1'b1) k = c;
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL single_latency: res_valid0 at cycle %0d after issue, expected 4 (0 = never)", k);
    end
    checks++;
    if (bus.res_data !== 32'h40400000 || bus.res_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_sum: res_data=%h rv1=%0b, expected 40400000 0", bus.res_data, bus.res_valid1);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_off: busy=%0b, expected 0", bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: res_valid0=%0b one cycle later, expected 0", bus.res_valid0);
    end
  endtask

  task automatic test_alternate();
    logic got;
    int   n;
    int   first_c;
    int   last_c;
    logic ids[$];
    apply_reset();
    tick();
    bus.a0_in = rand_fp();
    bus.b0_in = rand_fp();
    bus.a1_in = rand_fp();
    bus.b1_in = rand_fp();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = bus.gnt1;
      checks++;
      if ((bus.gnt0 ^ bus.gnt1) !== 1'b1 || got !== 1'(i % 2)) begin
        errors++;
        $display("FAIL alt_grant%0d: gnt0=%0b gnt1=%0b, expected grant to %0d", i, bus.gnt0, bus.gnt1, i % 2);
      end
      tick();
      if (got) begin
        bus.a1_in = rand_fp();
        bus.b1_in = rand_fp();
      end else begin
        bus.a0_in = rand_fp();
        bus.b0_in = rand_fp();
      end
    end
    set_idle();
    n = 0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.res_valid0 || bus.res_valid1) begin
        ids.push_back(bus.res_valid1);
        if (first_c < 0) first_c = c;
        last_c = c;
        n++;
      end
    end
    checks++;
    if (n != 4 || last_c - first_c != 3) begin
      errors++;
      $display("FAIL alt_results: %0d results spanning cycles %0d..%0d, expected 4 back-to-back", n, first_c, last_c);
    end
    checks++;
    if (ids.size() != 4 || ids[0] !== 1'b0 || ids[1] !== 1'b1 || ids[2] !== 1'b0 || ids[3] !== 1'b1) begin
      errors++;
      $display("FAIL alt_order: %0d results with ids %p, expected 0 1 0 1", ids.size(), ids);
    end
  endtask

  task automatic test_pointer();
    tick();
    bus.req0  = 1'b0;
    bus.req1  = 1'b1;
    bus.a1_in = rand_fp();
    bus.b1_in = rand_fp();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
        errors++;
        $display("FAIL ptr_solo%0d: gnt0=%0b gnt1=%0b, expected 0 1", i, bus.gnt0, bus.gnt1);
      end
      tick();
      bus.a1_in = rand_fp();
      bus.b1_in = rand_fp();
    end
    bus.req0  = 1'b1;
    bus.a0_in = rand_fp();
    bus.b0_in = rand_fp();
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL ptr_contested: gnt0=%0b gnt1=%0b, expected 1 0", bus.gnt0, bus.gnt1);
    end
    tick();
    set_idle();
    drain(6);
  endtask

  task automatic test_idle();
    int cnt0;
    int cnt1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.reg_A !== last_a || bus.reg_B !== last_b || bus.res_valid0 || bus.res_valid1) begin
        errors++;
        $display("FAIL idle_hold%0d: reg_A=%h reg_B=%h rv=%0b%0b, expected %h %h 00",
                 i, bus.reg_A, bus.reg_B, bus.res_valid1, bus.res_valid0, last_a, last_b);
      end
    end
    tick();
    bus.a0_in = rand_fp();
    bus.b0_in = rand_fp();
    bus.req0  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL idle_gnt: gnt0=%0b, expected 1", bus.gnt0);
    end
    tick();
    set_idle();
    cnt0 = 0;
    cnt1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.res_valid0) cnt0++;
      if (bus.res_valid1) cnt1++;
    end
    checks++;
    if (cnt0 != 1 || cnt1 != 0) begin
      errors++;
      $display("FAIL idle_single_result: rv0 pulses=%0d rv1 pulses=%0d, expected 1 0", cnt0, cnt1);
    end
  endtask

  task automatic test_mid_reset();
    int cnt;
    tick();
    bus.req0  = 1'b1;
    bus.req1  = 1'b0;
    bus.a0_in = rand_fp();
    bus.b0_in = rand_fp();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt0 !== 1'b1) begin
        errors++;
        $display("FAIL mid_issue%0d: gnt0=%0b, expected 1", i, bus.gnt0);
      end
      tick();
      bus.a0_in = rand_fp();
      bus.b0_in = rand_fp();
    end
    set_idle();
    @(negedge clk);
    @(posedge clk);
    #2;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    reset    = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.res_valid0, bus.res_valid1, bus.busy} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset_flags: gnt=%0b%0b rv=%0b%0b busy=%0b, expected all 0",
               bus.gnt1, bus.gnt0, bus.res_valid1, bus.res_valid0, bus.busy);
    end
    checks++;
    if ({bus.reg_A, bus.reg_B, bus.res_data} !== 96'd0) begin
      errors++;
      $display("FAIL mid_reset_regs: reg_A=%h reg_B=%h res_data=%h, expected all 0",
               bus.reg_A, bus.reg_B, bus.res_data);
    end
    @(negedge clk);
    set_idle();
    #2 reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid0 || bus.res_valid1) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL mid_reset_discard: %0d result pulses after reset, expected 0", cnt);
    end
    tick();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.a0_in = rand_fp();
    bus.b0_in = rand_fp();
    bus.a1_in = rand_fp();
    bus.b1_in = rand_fp();
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_prio: gnt0=%0b gnt1=%0b, expected 1 0", bus.gnt0, bus.gnt1);
    end
    tick();
    set_idle();
    drain(6);
  endtask

  task automatic test_random();
    logic g0;
    logic g1;
    int   grants;
    g0 = 1'b0;
    g1 = 1'b0;
    grants = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (!bus.req0 || g0) begin
        bus.req0  = ($urandom_range(0, 2) != 0);
        bus.a0_in = rand_fp();
        bus.b0_in = rand_fp();
      end
      if (!bus.req1 || g1) begin
        bus.req1  = ($urandom_range(0, 2) != 0);
        bus.a1_in = rand_fp();
        bus.b1_in = rand_fp();
      end
      @(negedge clk);
      g0 = bus.gnt0;
      g1 = bus.gnt1;
      if (g0 || g1) grants++;
      checks++;
      if ((bus.req0 || bus.req1) && !(g0 || g1)) begin
        errors++;
        $display("FAIL rand_stall: cycle %0d req=%0b%0b with no grant", c, bus.req1, bus.req0);
      end
    end
    tick();
    set_idle();
    drain(8);
    checks++;
    if (sb.size() != 0 || grants == 0) begin
      errors++;
      $display("FAIL rand_drain: %0d results outstanding after %0d grants, expected 0 outstanding", sb.size(), grants);
    end
  endtask

  initial begin
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.a0_in = 32'd0;
    bus.b0_in = 32'd0;
    bus.a1_in = 32'd0;
    bus.b1_in = 32'd0;
    test_reset();
    test_single();
    test_alternate();
    test_pointer();
    test_idle();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
